// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW front end: NOP bundle, fetch FSM states,
// default instruction-memory address width.
package vliw_pkg;

  localparam int DEFAULT_ADDR_W = 16;

  localparam logic [31:0] NOP_BUNDLE = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FULL,
    ST_DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue2.sv
// Two-entry {bundle, pc} FIFO between the fetch FSM and the IF/ID register.
// Flush empties it in one cycle and wins over push and pop.
module fetch_queue2
  import vliw_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [31:0]       push_bundle,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  output logic              valid,
  output logic [31:0]       head_bundle,
  output logic [ADDR_W-1:0] head_pc,
  output logic [1:0]        count
);

  logic [31:0]       bundle0, bundle1;
  logic [ADDR_W-1:0] pc0, pc1;
  logic              do_pop, do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  // Entry 0 is always the head; entry 1 only ever holds the younger bundle.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) begin
            bundle0 <= push_bundle;
            pc0     <= push_pc;
          end else begin
            bundle1 <= push_bundle;
            pc1     <= push_pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          bundle0 <= bundle1;
          pc0     <= pc1;
          count   <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            bundle0 <= push_bundle;
            pc0     <= push_pc;
          end else begin
            bundle0 <= bundle1;
            pc0     <= pc1;
            bundle1 <= push_bundle;
            pc1     <= push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid       = (count != 2'd0);
  assign head_bundle = valid ? bundle0 : NOP_BUNDLE;
  assign head_pc     = pc0;

endmodule

// File: rtl/vliw_fetch_unit.sv
// Instruction fetch for the two-slot VLIW core: one outstanding memory read,
// a two-bundle queue in front of IF/ID, and redirect/flush handling.
module vliw_fetch_unit
  import vliw_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       instr2Word,
  output logic [ADDR_W-1:0] if_pc
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc, pc_inc;
  logic              q_valid;
  logic [31:0]       q_bundle;
  logic [ADDR_W-1:0] q_pc;
  logic [1:0]        q_count;
  logic              deq, enq, goes_full;

  assign pc_inc    = pc + ADDR_W'(1);
  assign deq       = q_valid && !stall;
  assign enq       = (state == ST_REQ) && imem_ack && !redirect;
  // In REQ the queue holds at most one bundle, so a push without a pop fills it.
  assign goes_full = enq && !deq && (q_count != 2'd0);

  fetch_queue2 #(.ADDR_W(ADDR_W)) u_queue (
    .clk         (clk),
    .reset       (reset),
    .flush       (redirect),
    .push        (enq),
    .push_bundle (imem_rdata),
    .push_pc     (pc),
    .pop         (deq),
    .valid       (q_valid),
    .head_bundle (q_bundle),
    .head_pc     (q_pc),
    .count       (q_count)
  );

  // imem_addr only moves when a new request starts, so DROP keeps the old address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_REQ;
          imem_req <= 1'b1;
          if (redirect) begin
            pc        <= redirect_pc;
            imem_addr <= redirect_pc;
          end else begin
            imem_addr <= pc;
          end
        end
        ST_REQ: begin
          if (redirect) begin
            pc <= redirect_pc;
            if (imem_ack) begin
              state     <= ST_REQ;
              imem_addr <= redirect_pc;
            end else begin
              state <= ST_DROP;
            end
          end else if (imem_ack) begin
            pc <= pc_inc;
            if (goes_full) begin
              state    <= ST_FULL;
              imem_req <= 1'b0;
            end else begin
              imem_addr <= pc_inc;
            end
          end
        end
        ST_FULL: begin
          if (redirect) begin
            state     <= ST_REQ;
            pc        <= redirect_pc;
            imem_req  <= 1'b1;
            imem_addr <= redirect_pc;
          end else if (deq) begin
            state     <= ST_REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        ST_DROP: begin
          if (redirect) begin
            pc <= redirect_pc;
          end
          if (imem_ack) begin
            state     <= ST_REQ;
            imem_addr <= redirect ? redirect_pc : pc;
          end
        end
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign if_valid   = q_valid;
  assign instr2Word = q_bundle;
  assign if_pc      = q_valid ? q_pc : pc;

endmodule

// File: tb/tb_vliw_fetch_unit.sv
// Directed bench for vliw_fetch_unit: streaming, stall/full, redirect with
// drop and flush, PC wrap on a second instance, and reset during DROP.
module tb_vliw_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [15:0] redirect_pc;
  logic        imem_req, imem_ack, if_valid;
  logic [15:0] imem_addr, if_pc;
  logic [31:0] imem_rdata, instr2Word;

  logic        reset2;
  logic        imem_req2, if_valid2;
  logic [15:0] imem_addr2, if_pc2;
  logic [31:0] instr2Word2;

  logic        zero_wait, manual_ack, lat_ack;
  int          lat_cnt;
  int          tests = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // Memory returns addr+0x100; either same-cycle ack or ack 3 cycles after req rises.
  assign lat_ack    = imem_req && (lat_cnt == 3);
  assign imem_ack   = zero_wait ? imem_req : (lat_ack || manual_ack);
  assign imem_rdata = 32'(imem_addr) + 32'h100;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) lat_cnt <= 0;
    else                       lat_cnt <= lat_cnt + 1;
  end

  vliw_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .instr2Word  (instr2Word),
    .if_pc       (if_pc)
  );

  vliw_fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFE)) dut2 (
    .clk         (clk),
    .reset       (reset2),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (16'h0000),
    .imem_req    (imem_req2),
    .imem_addr   (imem_addr2),
    .imem_ack    (imem_req2),
    .imem_rdata  (32'(imem_addr2) + 32'h100),
    .if_valid    (if_valid2),
    .instr2Word  (instr2Word2),
    .if_pc       (if_pc2)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rst, input logic stl, input logic redir,
                               input logic [15:0] rpc);
    reset       = rst;
    stall       = stl;
    redirect    = redir;
    redirect_pc = rpc;
    step();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!if_valid && n < 20) begin
      step();
      n++;
    end
    checkOutput({tag, "_arrive"}, 32'(if_valid), 32'h1);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"}, 32'(if_valid), 32'h0);
    checkOutput({tag, "_instr"}, instr2Word, 32'h0);
    checkOutput({tag, "_pc"}, 32'(if_pc), 32'h0);
    checkOutput({tag, "_req"}, 32'(imem_req), 32'h0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    reset2 = 1'b0; zero_wait = 1'b1; manual_ack = 1'b0;
    repeat (2) step();

    // Reset values on both instances
    checkReset("rst");
    checkOutput("rst2_pc", 32'(if_pc2), 32'hFFFE);
    checkOutput("rst2_valid", 32'(if_valid2), 32'h0);

    // Zero-wait streaming
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    checkOutput("s1_idle_valid", 32'(if_valid), 32'h0);
    checkOutput("s1_req", 32'(imem_req), 32'h1);
    checkOutput("s1_addr", 32'(imem_addr), 32'h0);
    step();
    checkOutput("s1_b0", instr2Word, 32'h100);
    checkOutput("s1_pc0", 32'(if_pc), 32'h0);
    step();
    checkOutput("s1_b1", instr2Word, 32'h101);
    checkOutput("s1_pc1", 32'(if_pc), 32'h1);
    step();
    checkOutput("s1_b2", instr2Word, 32'h102);
    checkOutput("s1_pc2", 32'(if_pc), 32'h2);

    // Stall for 5 cycles after the first bundle
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkReset("s2_rst");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    step();
    checkOutput("s2_first", instr2Word, 32'h100);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
      checkOutput($sformatf("s2_hold%0d", i), instr2Word, 32'h100);
      checkOutput($sformatf("s2_full_req%0d", i), 32'(imem_req), 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    checkOutput("s2_rel_b1", instr2Word, 32'h101);
    checkOutput("s2_rel_pc1", 32'(if_pc), 32'h1);
    checkOutput("s2_rel_req", 32'(imem_req), 32'h1);
    checkOutput("s2_rel_addr", 32'(imem_addr), 32'h2);
    step();
    checkOutput("s2_rel_b2", instr2Word, 32'h102);
    step();
    checkOutput("s2_rel_b3", instr2Word, 32'h103);

    // Latency-3 memory, redirect one cycle after req rises -> DROP
    zero_wait = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    checkOutput("s3_req", 32'(imem_req), 32'h1);
    step();
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0040);
    redirect = 1'b0;
    checkOutput("s3_drop_req", 32'(imem_req), 32'h1);
    checkOutput("s3_drop_addr", 32'(imem_addr), 32'h0);
    step();
    checkOutput("s3_drop_ack", 32'(imem_ack), 32'h1);
    checkOutput("s3_drop_addr2", 32'(imem_addr), 32'h0);
    step();
    checkOutput("s3_new_addr", 32'(imem_addr), 32'h40);
    checkOutput("s3_no_valid", 32'(if_valid), 32'h0);
    waitValid("s3");
    checkOutput("s3_pc", 32'(if_pc), 32'h40);
    checkOutput("s3_instr", instr2Word, 32'h140);

    // Redirect coincident with ack while streaming -> flush, refetch at 0x20
    zero_wait = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    step();
    step();
    checkOutput("s4_pre", instr2Word, 32'h101);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0020);
    redirect = 1'b0;
    checkOutput("s4_flush_valid", 32'(if_valid), 32'h0);
    checkOutput("s4_flush_instr", instr2Word, 32'h0);
    checkOutput("s4_addr", 32'(imem_addr), 32'h20);
    step();
    checkOutput("s4_pc", 32'(if_pc), 32'h20);
    checkOutput("s4_instr", instr2Word, 32'h120);

    // PC wrap on the RESET_PC=0xFFFE instance
    reset2 = 1'b1;
    step();
    step();
    checkOutput("s5_pc0", 32'(if_pc2), 32'hFFFE);
    checkOutput("s5_b0", instr2Word2, 32'h100FE);
    step();
    checkOutput("s5_pc1", 32'(if_pc2), 32'hFFFF);
    step();
    checkOutput("s5_pc2", 32'(if_pc2), 32'h0000);
    checkOutput("s5_b2", instr2Word2, 32'h100);

    // Reset while in DROP with an ack pending; a late ack must be ignored
    zero_wait = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0040);
    redirect = 1'b0;
    checkOutput("s6_in_drop", 32'(imem_addr), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkReset("s6_rst");
    manual_ack = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    manual_ack = 1'b0;
    checkOutput("s6_late_valid", 32'(if_valid), 32'h0);
    checkOutput("s6_req", 32'(imem_req), 32'h1);
    checkOutput("s6_addr", 32'(imem_addr), 32'h0);
    waitValid("s6");
    checkOutput("s6_pc", 32'(if_pc), 32'h0);
    checkOutput("s6_instr", instr2Word, 32'h100);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
